// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one byte-wide synchronous memory port between an instruction-fetch
// (IF) client and a load/store (LS) client. A request is accepted in IDLE.
// LS has priority over IF. The transfer then runs one byte per cycle,
// little-endian, for 1, 2 or 4 bytes. A one-cycle done pulse goes to the
// owner, and the following cycle is an idle turnaround.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   rdy             global pause; low freezes the engine and masks mem_wr
//   if_req/if_addr  fetch request and byte address (fetches are 4 bytes)
//   if_abort        cancels an IF-owned read; blocks IF acceptance in IDLE
//   if_done/if_data fetch completion pulse and fetched word
//   ls_req/ls_we    load/store request, 1 = store
//   ls_size         0 = byte, 1 = half, 2/3 = word
//   ls_addr/wdata   load/store address and store data
//   ls_done/rdata   load/store completion pulse and zero-extended load data
//   mem_din         memory read byte (returns mem[mem_a] one cycle later)
//   mem_dout/a/wr   memory write byte, address and write strobe
//   busy            engine is not idle
// ---------------------------------------------------------------------------
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_abort,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_cnt, w_cnt_nxt;
    logic        r_owner_ls, w_owner_ls_nxt;
    logic [2:0]  r_len, w_len_nxt;
    logic [31:0] r_wdata, w_wdata_nxt;
    logic [31:0] r_buf, w_buf_nxt;
    logic [31:0] r_mem_a, w_mem_a_nxt;
    logic [7:0]  r_mem_dout, w_mem_dout_nxt;
    logic        r_mem_wr, w_mem_wr_nxt;
    logic        r_if_done, w_if_done_nxt;
    logic        r_ls_done, w_ls_done_nxt;
    logic [31:0] r_if_data, w_if_data_nxt;
    logic [31:0] r_ls_rdata, w_ls_rdata_nxt;

    logic        w_accept_ls, w_accept_if, w_abort, w_last_rd, w_last_wr;
    logic [1:0]  w_cap_idx;
    logic [31:0] w_rd_word;

    function automatic logic [2:0] size_to_len(input logic [1:0] size);
        case (size)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    return word[7:0];
            2'd1:    return word[15:8];
            2'd2:    return word[23:16];
            default: return word[31:24];
        endcase
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] res;
        res = word;
        case (idx)
            2'd0:    res[7:0]   = b;
            2'd1:    res[15:8]  = b;
            2'd2:    res[23:16] = b;
            default: res[31:24] = b;
        endcase
        return res;
    endfunction

    // No acceptance while a done pulse is out: that cycle is the turnaround.
    assign w_accept_ls = (r_state == S_IDLE) && rdy && !r_if_done && !r_ls_done && ls_req;
    assign w_accept_if = (r_state == S_IDLE) && rdy && !r_if_done && !r_ls_done && !ls_req
                         && if_req && !if_abort;
    assign w_abort     = (r_state == S_READ) && rdy && !r_owner_ls && if_abort;
    // In READ cnt runs to n: cycle k issues byte k and captures byte k-1.
    assign w_last_rd   = (r_state == S_READ) && rdy && (r_cnt == r_len);
    assign w_last_wr   = (r_state == S_WRITE) && rdy && (r_cnt == r_len - 3'd1);
    assign w_cap_idx   = 2'(r_cnt - 3'd1);
    assign w_rd_word   = put_byte(r_buf, w_cap_idx, mem_din);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept_ls) begin
                    w_state_nxt = ls_we ? S_WRITE : S_READ;
                end else if (w_accept_if) begin
                    w_state_nxt = S_READ;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_READ: begin
                if (w_abort || w_last_rd) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_READ;
                end
            end
            S_WRITE: begin
                if (w_last_wr) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WRITE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the latched request, byte engine and registered outputs.
    always_comb begin
        w_cnt_nxt      = r_cnt;
        w_owner_ls_nxt = r_owner_ls;
        w_len_nxt      = r_len;
        w_wdata_nxt    = r_wdata;
        w_buf_nxt      = r_buf;
        w_mem_a_nxt    = r_mem_a;
        w_mem_dout_nxt = r_mem_dout;
        w_mem_wr_nxt   = r_mem_wr;
        w_if_done_nxt  = 1'b0;
        w_ls_done_nxt  = 1'b0;
        w_if_data_nxt  = r_if_data;
        w_ls_rdata_nxt = r_ls_rdata;
        case (r_state)
            S_IDLE: begin
                if (w_accept_ls) begin
                    w_owner_ls_nxt = 1'b1;
                    w_len_nxt      = size_to_len(ls_size);
                    w_wdata_nxt    = ls_wdata;
                    w_cnt_nxt      = 3'd0;
                    w_buf_nxt      = 32'd0;
                    w_mem_a_nxt    = ls_addr;
                    w_mem_dout_nxt = ls_we ? ls_wdata[7:0] : 8'd0;
                    w_mem_wr_nxt   = ls_we;
                end else if (w_accept_if) begin
                    w_owner_ls_nxt = 1'b0;
                    w_len_nxt      = 3'd4;
                    w_cnt_nxt      = 3'd0;
                    w_buf_nxt      = 32'd0;
                    w_mem_a_nxt    = if_addr;
                    w_mem_dout_nxt = 8'd0;
                    w_mem_wr_nxt   = 1'b0;
                end else begin
                    w_mem_dout_nxt = 8'd0;
                    w_mem_wr_nxt   = 1'b0;
                end
            end
            S_READ: begin
                if (!rdy || w_abort) begin
                    w_cnt_nxt = r_cnt;
                end else if (w_last_rd) begin
                    if (r_owner_ls) begin
                        w_ls_done_nxt  = 1'b1;
                        w_ls_rdata_nxt = w_rd_word;
                    end else begin
                        w_if_done_nxt  = 1'b1;
                        w_if_data_nxt  = w_rd_word;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 3'd1;
                    // Nothing to capture yet in cycle 0.
                    if (r_cnt != 3'd0) begin
                        w_buf_nxt = w_rd_word;
                    end else begin
                        w_buf_nxt = r_buf;
                    end
                    // Address stops at the last byte; it is held into IDLE.
                    if ((r_cnt + 3'd1) < r_len) begin
                        w_mem_a_nxt = r_mem_a + 32'd1;
                    end else begin
                        w_mem_a_nxt = r_mem_a;
                    end
                end
            end
            S_WRITE: begin
                if (!rdy) begin
                    w_cnt_nxt = r_cnt;
                end else if (w_last_wr) begin
                    w_ls_done_nxt  = 1'b1;
                    w_mem_wr_nxt   = 1'b0;
                    w_mem_dout_nxt = 8'd0;
                end else begin
                    w_cnt_nxt      = r_cnt + 3'd1;
                    w_mem_a_nxt    = r_mem_a + 32'd1;
                    w_mem_dout_nxt = get_byte(r_wdata, 2'(r_cnt + 3'd1));
                    w_mem_wr_nxt   = 1'b1;
                end
            end
            default: begin
                w_mem_wr_nxt   = 1'b0;
                w_mem_dout_nxt = 8'd0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= 3'd0;
            r_owner_ls <= 1'b0;
            r_len      <= 3'd0;
            r_wdata    <= 32'd0;
            r_buf      <= 32'd0;
            r_mem_a    <= 32'd0;
            r_mem_dout <= 8'd0;
            r_mem_wr   <= 1'b0;
            r_if_done  <= 1'b0;
            r_ls_done  <= 1'b0;
            r_if_data  <= 32'd0;
            r_ls_rdata <= 32'd0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_owner_ls <= w_owner_ls_nxt;
            r_len      <= w_len_nxt;
            r_wdata    <= w_wdata_nxt;
            r_buf      <= w_buf_nxt;
            r_mem_a    <= w_mem_a_nxt;
            r_mem_dout <= w_mem_dout_nxt;
            r_mem_wr   <= w_mem_wr_nxt;
            r_if_done  <= w_if_done_nxt;
            r_ls_done  <= w_ls_done_nxt;
            r_if_data  <= w_if_data_nxt;
            r_ls_rdata <= w_ls_rdata_nxt;
        end
    end

    // The write strobe must drop in the same cycle rdy falls, so it is gated here.
    assign mem_wr   = r_mem_wr & rdy;
    assign mem_a    = r_mem_a;
    assign mem_dout = r_mem_dout;
    assign if_done  = r_if_done;
    assign ls_done  = r_ls_done;
    assign if_data  = r_if_data;
    assign ls_rdata = r_ls_rdata;
    assign busy     = (r_state != S_IDLE);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising edge; rst  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have ports: rdy  in  1  pause when low; if_req  in  1  fetch request; if_addr  in  32  fetch byte address; if_abort  in  1  cancel fetch (branch taken).
REQ-003 SHALL have ports: if_done  out  1  fetch complete pulse; if_data  out  32  fetched word.
REQ-004 SHALL have ports: ls_req  in  1  load/store request; ls_we  in  1  1=store; ls_size  in  2  0=byte, 1=half, 2=word (3 treated as word); ls_addr  in  32; ls_wdata  in  32.
REQ-005 SHALL have ports: ls_done  out  1  load/store complete pulse; ls_rdata  out  32  loaded bytes, zero-extended.
REQ-006 SHALL have ports: mem_din  in  8; mem_dout  out  8; mem_a  out  32; mem_wr  out  1  (1=write); busy  out  1  state != IDLE.

Function
REQ-007 SHALL implement states IDLE, READ, WRITE, plus a byte counter cnt (3 bits) and a latched owner (IF or LS), length n (1/2/4), base address and write data.
REQ-008 In IDLE, with rdy=1 and no done pulse asserted this cycle, SHALL accept ls_req in preference to if_req on the clock edge; when both are high, LS wins and IF stays pending.
REQ-009 On acceptance SHALL latch the request; go to READ (fetch, or load) or WRITE (store); set cnt=0; fetch length n=4.
REQ-010 READ: cycle k (k=0..n-1) SHALL drive mem_a=base+k, mem_wr=0; mem_din sampled in cycle k+1 SHALL be stored as result byte k (little-endian, byte 0 = bits 7:0).
REQ-011 READ SHALL complete when byte n-1 is captured: the done pulse of the owner is high exactly n+1 cycles after the acceptance edge; the data output is valid in the same cycle and held until the next completion.
REQ-012 WRITE: cycle k SHALL drive mem_a=base+k, mem_dout=ls_wdata byte k, mem_wr=1; ls_done SHALL pulse in the cycle after byte n-1 is driven (n cycles after acceptance).
REQ-013 SHALL return to IDLE in the done cycle; done pulses SHALL last exactly one cycle; the done cycle SHALL NOT accept a new request (one idle turnaround), so requests held until done are never accepted twice.
REQ-014 if_done and ls_done SHALL never be high together; only the owner's done pulses.
REQ-015 if_abort=1 while owner=IF in READ SHALL return to IDLE on the next edge without an if_done pulse; if_abort in IDLE SHALL suppress IF acceptance that cycle; if_abort SHALL be ignored when owner=LS.
REQ-016 rdy=0 SHALL freeze state, cnt, latched data and outputs, except that mem_wr is forced to 0; no request is accepted and no done pulse is asserted; operation resumes from the same byte when rdy returns to 1 (the pending read byte is re-issued).
REQ-017 Outside WRITE, mem_wr SHALL be 0 and mem_dout SHALL be 0; in IDLE, mem_a SHALL hold its last value.
REQ-018 Address increment SHALL be 32-bit modulo 2^32 (0xFFFFFFFF+1 -> 0x0); no alignment check; ls_rdata upper bytes beyond n SHALL be 0.
REQ-019 The request inputs SHALL be sampled only at acceptance; later changes on ls_*/if_addr mid-transaction SHALL have no effect.

Reset
REQ-020 rst=1 SHALL asynchronously force state IDLE, cnt=0, mem_a=0, mem_dout=0, mem_wr=0, if_done=0, ls_done=0, if_data=0, ls_rdata=0, busy=0.
REQ-021 Reset asserted mid-transaction SHALL abandon it with no done pulse; after release, the first acceptance is possible on the first rdy=1 edge.

Verification
REQ-022 Fetch: if_req, if_addr=0x100, memory bytes 13 05 00 00 -> mem_a 0x100..0x103 on consecutive cycles, if_done pulses 5 cycles after acceptance, if_data=0x00000513.
REQ-023 Contention: if_req and ls_req (load, word, 0x2000) together -> load served first, ls_done then one idle cycle, then fetch accepted; no overlap of dones.
REQ-024 Store half: ls_we=1, size=1, addr=0x30000, wdata=0xAABBCCDD -> mem_wr=1 for 2 cycles, (0x30000,0xDD),(0x30001,0xCC); ls_done 2 cycles after acceptance.
REQ-025 Abort: fetch at 0x40, if_abort in the 3rd READ cycle -> IDLE next edge, no if_done; a new fetch at 0x80 completes normally.
REQ-026 Pause: rdy=0 for 3 cycles during byte 2 of a word load -> mem_wr=0, no progress; completion delayed exactly 3 cycles with correct data.
REQ-027 Reset mid-store: rst pulse after byte 1 -> outputs zero immediately, no ls_done, busy=0.
